// File: rtl/vga_vram_scanner.sv
// rtl/vga_vram_scanner.sv - 640x480 raster scanner over three 1-bpp VRAM planes
// Each VRAM pixel is upscaled to a SCALE x SCALE block; video outputs lag the counters by one pixel.
module vga_vram_scanner #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int SCALE   = 5,
  parameter int IMG_W   = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] vram_addr,
  input  logic        vram_r,
  input  logic        vram_g,
  input  logic        vram_b,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(PIX_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = $clog2(SCALE);
  localparam int CW      = $clog2(IMG_W);
  localparam int ROW_MAX = V_VIS / SCALE - 1;

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [SW-1:0] r_hsub;
  logic [SW-1:0] r_vsub;
  logic [CW-1:0] r_col;
  logic [6:0]    r_row;
  logic [3:0]    r_vga_r;
  logic [3:0]    r_vga_g;
  logic [3:0]    r_vga_b;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_visible;
  logic          w_hs_active;
  logic          w_vs_active;

  assign w_tick      = (r_div == DW'(PIX_DIV - 1));
  assign w_h_last    = (r_hcnt == HW'(H_TOTAL - 1));
  assign w_v_last    = (r_vcnt == VW'(V_TOTAL - 1));
  assign w_h_next    = w_h_last ? '0 : r_hcnt + 1'b1;
  assign w_v_next    = w_v_last ? '0 : r_vcnt + 1'b1;
  assign w_visible   = (r_hcnt < HW'(H_VIS)) && (r_vcnt < VW'(V_VIS));
  assign w_hs_active = (r_hcnt >= HW'(H_VIS + H_FP)) && (r_hcnt < HW'(H_VIS + H_FP + H_SYNC));
  assign w_vs_active = (r_vcnt >= VW'(V_VIS + V_FP)) && (r_vcnt < VW'(V_VIS + V_FP + V_SYNC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_tick) begin
      r_hcnt <= w_h_next;
      if (w_h_last) begin
        r_vcnt <= w_v_next;
      end
    end
  end

  // Image column steps only while the upcoming screen pixel is visible, so it freezes in blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsub <= '0;
      r_col  <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_hsub <= '0;
        r_col  <= '0;
      end else if (w_h_next < HW'(H_VIS)) begin
        if (r_hsub == SW'(SCALE - 1)) begin
          r_hsub <= '0;
          if (r_col != CW'(IMG_W - 1)) begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_hsub <= r_hsub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsub <= '0;
      r_row  <= '0;
    end else if (w_tick && w_h_last) begin
      if (w_v_last) begin
        r_vsub <= '0;
        r_row  <= '0;
      end else if (w_v_next < VW'(V_VIS)) begin
        if (r_vsub == SW'(SCALE - 1)) begin
          r_vsub <= '0;
          if (r_row != 7'(ROW_MAX)) begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_vsub <= r_vsub + 1'b1;
        end
      end
    end
  end

  assign vram_addr = 14'({7'd0, r_row} << CW) + 14'(r_col);

  // RAM data was addressed at least PIX_DIV-1 clocks ago, so capturing on the tick is hazard-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_r <= 4'h0;
      r_vga_g <= 4'h0;
      r_vga_b <= 4'h0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_vga_r <= w_visible ? {4{vram_r}} : 4'h0;
      r_vga_g <= w_visible ? {4{vram_g}} : 4'h0;
      r_vga_b <= w_visible ? {4{vram_b}} : 4'h0;
      r_hsync <= ~w_hs_active;
      r_vsync <= ~w_vs_active;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_last && w_v_last;
    end
  end

  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_vram_scanner.sv
// tb/tb_vga_vram_scanner.sv - bench for vga_vram_scanner with a reduced raster geometry
module tb_vga_vram_scanner;

  localparam int P  = 4;
  localparam int HV = 40;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int VV = 15;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int S  = 5;
  localparam int IW = 8;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FC = P * HT * VT;

  logic        clk;
  logic        reset;
  logic [13:0] vram_addr;
  logic        vram_r;
  logic        vram_g;
  logic        vram_b;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  bit mem_r [0:16383];
  bit mem_g [0:16383];
  bit mem_b [0:16383];

  int n;
  int phase;
  int n_cmp;
  int n_bad;
  int p, q, h, v, a, vis;
  int e_addr, e_r, e_g, e_b, e_hs, e_vs, e_fs;
  int hs_prev, hs_low, vs_prev, vs_low, last_fs;

  vga_vram_scanner #(
    .PIX_DIV(P), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(S), .IMG_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vram_addr(vram_addr),
    .vram_r(vram_r),
    .vram_g(vram_g),
    .vram_b(vram_b),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read VRAM planes
  always @(posedge clk) begin
    vram_r <= mem_r[vram_addr];
    vram_g <= mem_g[vram_addr];
    vram_b <= mem_b[vram_addr];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at clk %0d (phase %0d): actual=%0d required=%0d", nm, n, phase, act, exp);
    end
  endtask

  // Address of the VRAM pixel shown at screen pixel index qq counted from scan start
  function automatic int m_addr(input int qq);
    int hh, vv, col, row;
    hh  = qq % HT;
    vv  = (qq / HT) % VT;
    col = ((hh < HV) ? hh : HV - 1) / S;
    row = ((vv < VV) ? vv : VV - 1) / S;
    if (col > IW - 1) col = IW - 1;
    if (row > VV / S - 1) row = VV / S - 1;
    return row * IW + col;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_addr", int'(vram_addr), 0);
      chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_frame_start", int'(frame_start), 0);
      hs_prev = 1; hs_low = 0; vs_prev = 1; vs_low = 0; last_fs = -1;
    end else begin
      p = n / P;
      e_addr = m_addr(p);
      if (p == 0) begin
        e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1;
      end else begin
        q   = p - 1;
        h   = q % HT;
        v   = (q / HT) % VT;
        a   = m_addr(q);
        vis = (h < HV && v < VV) ? 1 : 0;
        e_r = (vis == 1 && mem_r[a]) ? 15 : 0;
        e_g = (vis == 1 && mem_g[a]) ? 15 : 0;
        e_b = (vis == 1 && mem_b[a]) ? 15 : 0;
        e_hs = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
        e_vs = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
      end
      e_fs = (p > 0 && n % P == 0 && p % (HT * VT) == 0) ? 1 : 0;
      chk("addr", int'(vram_addr), e_addr);
      chk("vga_r", int'(vga_r), e_r);
      chk("vga_g", int'(vga_g), e_g);
      chk("vga_b", int'(vga_b), e_b);
      chk("hsync", int'(hsync), e_hs);
      chk("vsync", int'(vsync), e_vs);
      chk("frame_start", int'(frame_start), e_fs);

      if (n == 19)   chk("lit_addr_n19", int'(vram_addr), 0);
      if (n == 20)   chk("lit_addr_n20", int'(vram_addr), 1);
      if (n == 1119) chk("lit_addr_line4_end", int'(vram_addr), 7);
      if (n == 1120) chk("lit_addr_line5_start", int'(vram_addr), 8);
      if (n == 3292) chk("lit_addr_last_vis", int'(vram_addr), 23);
      if (n == 3336) chk("lit_addr_hblank_hold", int'(vram_addr), 23);
      if (n == 179)  chk("lit_hsync_pre_fall", int'(hsync), 1);
      if (n == 180)  chk("lit_hsync_fall", int'(hsync), 0);
      if (n == 3811) chk("lit_vsync_pre_fall", int'(vsync), 1);
      if (n == 3812) chk("lit_vsync_fall", int'(vsync), 0);
      if (n == 4928) chk("lit_frame_start", int'(frame_start), 1);
      if (phase < 2) begin
        if (n == 3)  chk("lit_align_n3", int'(vga_r), 0);
        if (n == 4)  chk("lit_align_n4", int'(vga_r), 15);
        if (n == 23) chk("lit_align_n23", int'(vga_r), 15);
        if (n == 24) chk("lit_align_n24", int'(vga_r), 0);
      end else begin
        if (n == 100)  chk("lit_colour", int'({vga_r, vga_g, vga_b}), 12'hF0F);
        if (n == 184)  chk("lit_hblank_mask", int'({vga_r, vga_g, vga_b}), 0);
        if (n == 3404) chk("lit_vblank_mask", int'({vga_r, vga_g, vga_b}), 0);
      end

      if (!hsync) hs_low++;
      if (hsync && hs_prev == 0) begin
        chk("hsync_low_clks", hs_low, P * HS);
        hs_low = 0;
      end
      hs_prev = int'(hsync);
      if (!vsync) vs_low++;
      if (vsync && vs_prev == 0) begin
        chk("vsync_low_clks", vs_low, P * HT * VS);
        vs_low = 0;
      end
      vs_prev = int'(vsync);
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", n - last_fs, FC);
        last_fs = n;
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    phase = 0;
    reset = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      mem_r[i] = (i == 0);
      mem_g[i] = i[0];
      mem_b[i] = i[1] ^ i[2];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (301) @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    phase = 1;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2 * FC + 240) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    phase = 2;
    for (int i = 0; i < 16384; i++) begin
      mem_r[i] = 1'b1;
      mem_g[i] = 1'b0;
      mem_b[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (4000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
